// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response framing stage.
// Imported by the RX framing top and the TX response handshake.
package uart_cmd_pkg;

    typedef enum logic {
        RX_HIGH = 1'b0,
        RX_LOW  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ARM  = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

    // High byte arrives first on the wire, so it lands in the upper half.
    function automatic logic [CMD_W-1:0] join_cmd(
        input logic [BYTE_W-1:0] hi_byte,
        input logic [BYTE_W-1:0] lo_byte
    );
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response handshake toward the UART transmitter: latch one byte, pulse trmt,
// then wait for tx_done before accepting another response.
module uart_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send_resp,
    input  logic [BYTE_W-1:0] resp,
    input  logic              tx_done,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    output logic              resp_busy,
    output logic              resp_sent
);

    tx_state_t         state_r;
    tx_state_t         state_nxt_s;
    logic [BYTE_W-1:0] tx_data_r;
    logic [BYTE_W-1:0] tx_data_nxt_s;
    logic              trmt_r;
    logic              trmt_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              sent_r;
    logic              sent_nxt_s;

    // Next-state and next-output decode; outputs are registered so they track the state exactly.
    always_comb begin
        state_nxt_s   = state_r;
        tx_data_nxt_s = tx_data_r;
        trmt_nxt_s    = 1'b0;
        busy_nxt_s    = 1'b0;
        sent_nxt_s    = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_nxt_s = resp;
                    state_nxt_s   = TX_ARM;
                    trmt_nxt_s    = 1'b1;
                    busy_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s   = TX_IDLE;
                end
            end
            TX_ARM: begin
                // tx_done may still show the previous byte here, so it is not looked at.
                state_nxt_s = TX_WAIT;
                busy_nxt_s  = 1'b1;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    state_nxt_s = TX_IDLE;
                    sent_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= TX_IDLE;
            tx_data_r <= 8'h00;
            trmt_r    <= 1'b0;
            busy_r    <= 1'b0;
            sent_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            tx_data_r <= tx_data_nxt_s;
            trmt_r    <= trmt_nxt_s;
            busy_r    <= busy_nxt_s;
            sent_r    <= sent_nxt_s;
        end
    end

    assign trmt      = trmt_r;
    assign tx_data   = tx_data_r;
    assign resp_busy = busy_r;
    assign resp_sent = sent_r;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Frames received UART bytes into 16-bit commands (high byte first, with an
// inter-byte timeout) and hands one-byte responses back to the transmitter.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter  int TIMEOUT_CYC = 100000,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_rdy,
    input  logic [BYTE_W-1:0]   rx_data,
    output logic                clr_rx_rdy,
    output logic                cmd_rdy,
    output logic [CMD_W-1:0]    cmd,
    input  logic                clr_cmd_rdy,
    output logic                frm_err,
    input  logic                send_resp,
    input  logic [BYTE_W-1:0]   resp,
    output logic                trmt,
    output logic [BYTE_W-1:0]   tx_data,
    input  logic                tx_done,
    output logic                resp_busy,
    output logic                resp_sent
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rx_state_t         rx_state_r;
    rx_state_t         rx_state_nxt_s;
    logic [BYTE_W-1:0] high_r;
    logic [BYTE_W-1:0] high_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CMD_W-1:0]  cmd_r;
    logic [CMD_W-1:0]  cmd_nxt_s;
    logic              cmd_rdy_r;
    logic              cmd_rdy_nxt_s;
    logic              frm_err_r;
    logic              frm_err_nxt_s;

    // Every byte is taken the cycle it is offered, in either framing state.
    assign clr_rx_rdy = rx_rdy & rst_n;

    // RX framing decode: high/low byte assembly, timeout, and cmd_rdy handshake.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        high_nxt_s     = high_r;
        cnt_nxt_s      = cnt_r;
        cmd_nxt_s      = cmd_r;
        cmd_rdy_nxt_s  = cmd_rdy_r & ~clr_cmd_rdy;
        frm_err_nxt_s  = 1'b0;
        case (rx_state_r)
            RX_HIGH: begin
                if (rx_rdy) begin
                    // A fresh command start supersedes any unconsumed one.
                    high_nxt_s     = rx_data;
                    cmd_rdy_nxt_s  = 1'b0;
                    cnt_nxt_s      = '0;
                    rx_state_nxt_s = RX_LOW;
                end else begin
                    rx_state_nxt_s = RX_HIGH;
                end
            end
            RX_LOW: begin
                if (rx_rdy) begin
                    // Byte beats a coincident timeout; set beats a coincident clear.
                    cmd_nxt_s      = join_cmd(high_r, rx_data);
                    cmd_rdy_nxt_s  = 1'b1;
                    cnt_nxt_s      = '0;
                    rx_state_nxt_s = RX_HIGH;
                end else if (cnt_r == CNT_LAST) begin
                    frm_err_nxt_s  = 1'b1;
                    cnt_nxt_s      = '0;
                    rx_state_nxt_s = RX_HIGH;
                end else begin
                    cnt_nxt_s      = cnt_r + CNT_W'(1);
                    rx_state_nxt_s = RX_LOW;
                end
            end
            default: begin
                rx_state_nxt_s = RX_HIGH;
                cnt_nxt_s      = '0;
            end
        endcase
    end

    // RX framing registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_r <= RX_HIGH;
            high_r     <= 8'h00;
            cnt_r      <= '0;
            cmd_r      <= 16'h0000;
            cmd_rdy_r  <= 1'b0;
            frm_err_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            high_r     <= high_nxt_s;
            cnt_r      <= cnt_nxt_s;
            cmd_r      <= cmd_nxt_s;
            cmd_rdy_r  <= cmd_rdy_nxt_s;
            frm_err_r  <= frm_err_nxt_s;
        end
    end

    assign cmd     = cmd_r;
    assign cmd_rdy = cmd_rdy_r;
    assign frm_err = frm_err_r;

    uart_resp_tx u_resp_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_busy (resp_busy),
        .resp_sent (resp_sent)
    );

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Command/response framing stage that sits directly downstream of the UART receiver and upstream of the UART transmitter. It consumes bytes via rx_rdy/rx_data/clr_rx_rdy and assembles two consecutive bytes, high byte first, into a 16-bit command for the command processor. It returns a one-byte response from the processor through trmt/tx_data/tx_done. A timeout discards a lone high byte when the low byte never arrives.

Parameters:
TIMEOUT_CYC, 100000, max clk cycles allowed between high-byte capture and low-byte arrival before the partial command is discarded; must be >= 2
CNT_W, $clog2(TIMEOUT_CYC+1), width of the inter-byte timeout counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
rx_rdy  input  1  receiver holds a valid byte
rx_data  input  8  received byte
clr_rx_rdy  output  1  one-cycle pulse: byte consumed
cmd_rdy  output  1  level: cmd holds a complete, unconsumed command
cmd  output  16  assembled command {high byte, low byte}
clr_cmd_rdy  input  1  processor has consumed cmd
frm_err  output  1  one-cycle pulse: partial command discarded on timeout
send_resp  input  1  request to transmit resp
resp  input  8  response byte, sampled when send_resp is accepted
trmt  output  1  one-cycle start pulse to transmitter
tx_data  output  8  byte to transmit, registered
tx_done  input  1  transmitter finished; cleared by transmitter on trmt
resp_busy  output  1  response path not idle; send_resp ignored while high
resp_sent  output  1  one-cycle pulse: response fully transmitted

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: rx FSM = RX_HIGH, tx FSM = TX_IDLE, cmd=16'h0000, cmd_rdy=0, tx_data=8'h00, timeout counter=0. clr_rx_rdy, frm_err, trmt, resp_sent are 0 and resp_busy is 0. Reset mid-operation abandons any partial command or response immediately.
- clr_rx_rdy is combinational: it equals rx_rdy in both rx states, so every byte is consumed in the cycle it is seen.
- RX_HIGH state, rx_rdy=1:
  - latch rx_data into a high-byte register.
  - clear cmd_rdy; a new command start supersedes an unconsumed one.
  - clear the counter and go to RX_LOW.
- RX_LOW state, rx_rdy=1:
  - cmd <= {high, rx_data}; cmd_rdy <= 1 on the same edge, so it is visible the cycle after the low byte.
  - go to RX_HIGH.
- RX_LOW state, rx_rdy=0:
  - the counter increments.
  - when the counter == TIMEOUT_CYC-1, pulse frm_err for one cycle, go to RX_HIGH, and leave cmd/cmd_rdy untouched.
- Timeout and low-byte arrival in the same cycle: the byte wins and no frm_err is raised.
- cmd changes only on low-byte completion and is stable while cmd_rdy=1.
- cmd_rdy clears on clr_cmd_rdy or on a high-byte capture. If a set and clr_cmd_rdy occur in the same cycle, the set wins.
- TX FSM, TX_IDLE:
  - send_resp=1: tx_data <= resp; go to TX_ARM.
- TX FSM, TX_ARM:
  - trmt=1 for exactly this cycle; tx_done is ignored.
  - go to TX_WAIT.
- TX FSM, TX_WAIT:
  - on tx_done=1, pulse resp_sent and go to TX_IDLE.
- resp_busy=1 in TX_ARM and TX_WAIT. send_resp in those states is dropped, not queued.
- Latency: send_resp accepted -> trmt high the next cycle.
- The RX and TX paths are independent and may be active in the same cycle.

Decomposition:
- Package uart_cmd_pkg holds:
  - typedef enum logic {RX_HIGH, RX_LOW} rx_state_t
  - typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_WAIT} tx_state_t
  - localparam CMD_W=16
- Natural sub-module: uart_resp_tx (the TX handshake FSM). The RX framing stays in the top module.
- Intended composition: top instantiates the existing UART block and this wrapper side by side.

Test Plan:
- Bytes 8'hA5 then 8'h3C, each rx_rdy pulse held until clr_rx_rdy -> one clr_rx_rdy per byte; cmd_rdy rises the cycle after the second byte with cmd=16'hA53C; stays high until clr_cmd_rdy.
- TIMEOUT_CYC=20: byte 8'h12, then silence for 25 cycles -> frm_err pulses exactly once, 20 cycles after capture. Then bytes 8'h34, 8'h56 -> cmd=16'h3456 with no stale 8'h12.
- cmd_rdy=1 with 16'hA53C unconsumed, new high byte 8'hFF -> cmd_rdy drops the next cycle and cmd holds 16'hA53C. Then low byte 8'h01 -> cmd=16'hFF01, cmd_rdy=1.
- clr_cmd_rdy asserted in the same cycle as the low-byte completion -> cmd_rdy=1 afterwards.
- send_resp with resp=8'hA5 and a bench transmitter model that raises tx_done 100 cycles after trmt -> trmt single-cycle pulse, tx_data=8'hA5. resp_busy is high throughout, and resp_sent pulses once.
- During resp_busy, send_resp with resp=8'h00 -> ignored and tx_data stays 8'hA5. Separately, rst_n=0 mid-frame and mid-response -> all outputs take their reset values on the next edge.
